// File: rtl/arp_table_lookup.sv
// rtl/arp_table_lookup.sv - ARP table with linear-search lookup responder and register-side table access
module arp_table_lookup #(
    parameter int NUM_ENTRIES = 32,
    parameter int IDX_WIDTH   = $clog2(NUM_ENTRIES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arp_lookup_req,
    input  logic [31:0]          arp_lookup_search_ip,
    output logic                 arp_lookup_done,
    output logic [47:0]          arp_lookup_result_mac,
    input  logic                 table_wr_req,
    input  logic [IDX_WIDTH-1:0] table_wr_index,
    input  logic [31:0]          table_wr_ip,
    input  logic [47:0]          table_wr_mac,
    input  logic                 table_rd_req,
    input  logic [IDX_WIDTH-1:0] table_rd_index,
    output logic [31:0]          table_rd_ip,
    output logic [47:0]          table_rd_mac,
    output logic                 table_ack,
    output logic                 cntr_arp_hits,
    output logic                 cntr_arp_lookups
);

    typedef enum logic [1:0] {IDLE, SEARCH, RESPOND, TABLE_OP} state_e;

    state_e               state_q, state_d;
    logic [31:0]          ip_q  [NUM_ENTRIES];
    logic [47:0]          mac_q [NUM_ENTRIES];
    logic [31:0]          search_ip_q;
    logic [IDX_WIDTH-1:0] idx_q;
    logic [47:0]          result_mac_q;
    logic [31:0]          rd_ip_q;
    logic [47:0]          rd_mac_q;
    logic                 op_wr_q;
    logic                 lookups_q;

    logic table_req;
    logic accept_lookup;
    logic entry_hit;
    logic last_entry;

    assign table_req     = table_wr_req | table_rd_req;
    assign accept_lookup = (state_q == IDLE) && !table_req && arp_lookup_req;
    // A zero IP marks an empty slot, so a search for 0 can never match.
    assign entry_hit     = (ip_q[idx_q] != '0) && (ip_q[idx_q] == search_ip_q);
    assign last_entry    = (idx_q == {IDX_WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (table_req) begin
                    state_d = TABLE_OP;
                end else if (arp_lookup_req) begin
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (!arp_lookup_req) begin
                    state_d = IDLE;
                end else if (entry_hit || last_entry) begin
                    state_d = RESPOND;
                end
            end
            RESPOND:  state_d = IDLE;
            TABLE_OP: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        arp_lookup_done       = (state_q == RESPOND);
        table_ack             = (state_q == TABLE_OP);
        cntr_arp_hits         = (state_q == RESPOND) && (result_mac_q != '0);
        cntr_arp_lookups      = lookups_q;
        arp_lookup_result_mac = result_mac_q;
        table_rd_ip           = rd_ip_q;
        table_rd_mac          = rd_mac_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ip_q[i]  <= '0;
                mac_q[i] <= '0;
            end
            search_ip_q  <= '0;
            idx_q        <= '0;
            result_mac_q <= '0;
            rd_ip_q      <= '0;
            rd_mac_q     <= '0;
            op_wr_q      <= 1'b0;
            lookups_q    <= 1'b0;
        end else begin
            lookups_q <= accept_lookup;
            case (state_q)
                IDLE: begin
                    if (table_req) begin
                        op_wr_q <= table_wr_req;
                        // Read data is captured on accept so it is already valid in the ack cycle.
                        if (!table_wr_req) begin
                            rd_ip_q  <= ip_q[table_rd_index];
                            rd_mac_q <= mac_q[table_rd_index];
                        end
                    end else if (arp_lookup_req) begin
                        search_ip_q <= arp_lookup_search_ip;
                        idx_q       <= '0;
                    end
                end
                SEARCH: begin
                    if (arp_lookup_req) begin
                        if (entry_hit) begin
                            result_mac_q <= mac_q[idx_q];
                        end else if (last_entry) begin
                            result_mac_q <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                TABLE_OP: begin
                    if (op_wr_q) begin
                        ip_q[table_wr_index]  <= table_wr_ip;
                        mac_q[table_wr_index] <= table_wr_mac;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arp_table_lookup.sv
// tb/tb_arp_table_lookup.sv - directed self-checking bench for arp_table_lookup
module tb_arp_table_lookup;

    logic        clk;
    logic        reset;
    logic        arp_lookup_req;
    logic [31:0] arp_lookup_search_ip;
    logic        arp_lookup_done;
    logic [47:0] arp_lookup_result_mac;
    logic        table_wr_req;
    logic [4:0]  table_wr_index;
    logic [31:0] table_wr_ip;
    logic [47:0] table_wr_mac;
    logic        table_rd_req;
    logic [4:0]  table_rd_index;
    logic [31:0] table_rd_ip;
    logic [47:0] table_rd_mac;
    logic        table_ack;
    logic        cntr_arp_hits;
    logic        cntr_arp_lookups;

    int n_cmp;
    int n_err;

    localparam logic [31:0] IP_A   = 32'h0A00_0005;
    localparam logic [47:0] MAC_A  = 48'h0011_2233_4455;
    localparam logic [31:0] IP_DUP = 32'h0A00_0007;
    localparam logic [47:0] MAC_7  = 48'hAAAA_AAAA_AA07;
    localparam logic [47:0] MAC_2  = 48'hBBBB_BBBB_BB02;
    localparam logic [31:0] IP_C   = 32'h0A00_0010;
    localparam logic [47:0] MAC_C  = 48'hC0C1_C2C3_C4C5;

    arp_table_lookup dut (
        .clk                   (clk),
        .reset                 (reset),
        .arp_lookup_req        (arp_lookup_req),
        .arp_lookup_search_ip  (arp_lookup_search_ip),
        .arp_lookup_done       (arp_lookup_done),
        .arp_lookup_result_mac (arp_lookup_result_mac),
        .table_wr_req          (table_wr_req),
        .table_wr_index        (table_wr_index),
        .table_wr_ip           (table_wr_ip),
        .table_wr_mac          (table_wr_mac),
        .table_rd_req          (table_rd_req),
        .table_rd_index        (table_rd_index),
        .table_rd_ip           (table_rd_ip),
        .table_rd_mac          (table_rd_mac),
        .table_ack             (table_ack),
        .cntr_arp_hits         (cntr_arp_hits),
        .cntr_arp_lookups      (cntr_arp_lookups)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle 0 of the returned latency is the cycle the request was first presented.
    task automatic table_op(input logic wr, input logic [4:0] idx, input logic [31:0] ip,
                            input logic [47:0] mac, output int lat,
                            output logic [31:0] rip, output logic [47:0] rmac);
        @(posedge clk); #1;
        if (wr) begin
            table_wr_req = 1'b1; table_wr_index = idx; table_wr_ip = ip; table_wr_mac = mac;
        end else begin
            table_rd_req = 1'b1; table_rd_index = idx;
        end
        lat = -1; rip = '0; rmac = '0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (table_ack) begin
                lat = n; rip = table_rd_ip; rmac = table_rd_mac;
                break;
            end
        end
        table_wr_req = 1'b0;
        table_rd_req = 1'b0;
    endtask

    task automatic run_lookup(input logic [31:0] ip, output int lat, output logic [47:0] mac,
                              output int hits, output int lks);
        @(posedge clk); #1;
        arp_lookup_req = 1'b1; arp_lookup_search_ip = ip;
        lat = -1; mac = '0; hits = 0; lks = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (cntr_arp_hits) hits++;
            if (cntr_arp_lookups) lks++;
            if (arp_lookup_done) begin
                lat = n; mac = arp_lookup_result_mac;
                break;
            end
        end
        arp_lookup_req = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (arp_lookup_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", arp_lookup_done); end
        n_cmp++; if (arp_lookup_result_mac !== 48'h0) begin n_err++; $display("FAIL reset_mac got %h want 0", arp_lookup_result_mac); end
        n_cmp++; if (table_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b want 0", table_ack); end
        n_cmp++; if (table_rd_ip !== 32'h0 || table_rd_mac !== 48'h0) begin n_err++; $display("FAIL reset_rd got %h/%h want 0/0", table_rd_ip, table_rd_mac); end
        n_cmp++; if (cntr_arp_hits !== 1'b0 || cntr_arp_lookups !== 1'b0) begin n_err++; $display("FAIL reset_cntr got %b/%b want 0/0", cntr_arp_hits, cntr_arp_lookups); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_hit_idx3;
        int lat; int hits; int lks; logic [31:0] rip; logic [47:0] rmac; logic [47:0] mac;
        table_op(1'b1, 5'd3, IP_A, MAC_A, lat, rip, rmac);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL hit3_wr_ack_lat got %0d want 1", lat); end
        run_lookup(IP_A, lat, mac, hits, lks);
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL hit3_lat got %0d want 5", lat); end
        n_cmp++; if (mac !== MAC_A) begin n_err++; $display("FAIL hit3_mac got %h want %h", mac, MAC_A); end
        n_cmp++; if (hits !== 1) begin n_err++; $display("FAIL hit3_hits got %0d want 1", hits); end
        n_cmp++; if (lks !== 1) begin n_err++; $display("FAIL hit3_lookups got %0d want 1", lks); end
    endtask

    task automatic test_empty_miss;
        int lat; int hits; int lks; logic [47:0] mac;
        run_lookup(32'h0A00_0009, lat, mac, hits, lks);
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL miss_lat got %0d want 33", lat); end
        n_cmp++; if (mac !== 48'h0) begin n_err++; $display("FAIL miss_mac got %h want 0", mac); end
        n_cmp++; if (hits !== 0) begin n_err++; $display("FAIL miss_hits got %0d want 0", hits); end
        n_cmp++; if (lks !== 1) begin n_err++; $display("FAIL miss_lookups got %0d want 1", lks); end
    endtask

    task automatic test_duplicate;
        int lat; int hits; int lks; logic [31:0] rip; logic [47:0] rmac; logic [47:0] mac;
        table_op(1'b1, 5'd7, IP_DUP, MAC_7, lat, rip, rmac);
        table_op(1'b1, 5'd2, IP_DUP, MAC_2, lat, rip, rmac);
        run_lookup(IP_DUP, lat, mac, hits, lks);
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL dup_lat got %0d want 4", lat); end
        n_cmp++; if (mac !== MAC_2) begin n_err++; $display("FAIL dup_mac got %h want %h", mac, MAC_2); end
    endtask

    task automatic test_collision;
        int ack_n; int done_n; int lks; logic [47:0] mac;
        @(posedge clk); #1;
        table_wr_req = 1'b1; table_wr_index = 5'd5; table_wr_ip = IP_C; table_wr_mac = MAC_C;
        arp_lookup_req = 1'b1; arp_lookup_search_ip = IP_C;
        ack_n = -1; done_n = -1; lks = 0; mac = '0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (cntr_arp_lookups) lks++;
            if (table_ack) begin ack_n = n; table_wr_req = 1'b0; end
            if (arp_lookup_done) begin done_n = n; mac = arp_lookup_result_mac; break; end
        end
        arp_lookup_req = 1'b0; table_wr_req = 1'b0;
        n_cmp++; if (ack_n !== 1) begin n_err++; $display("FAIL coll_ack_lat got %0d want 1", ack_n); end
        n_cmp++; if (done_n !== 9) begin n_err++; $display("FAIL coll_done_lat got %0d want 9", done_n); end
        n_cmp++; if (mac !== MAC_C) begin n_err++; $display("FAIL coll_mac got %h want %h", mac, MAC_C); end
        n_cmp++; if (lks !== 1) begin n_err++; $display("FAIL coll_lookups got %0d want 1", lks); end
    endtask

    task automatic test_readback_invalidate;
        int lat; int hits; int lks; logic [31:0] rip; logic [47:0] rmac; logic [47:0] mac;
        table_op(1'b0, 5'd3, 32'h0, 48'h0, lat, rip, rmac);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL rd_ack_lat got %0d want 1", lat); end
        n_cmp++; if (rip !== IP_A) begin n_err++; $display("FAIL rd_ip got %h want %h", rip, IP_A); end
        n_cmp++; if (rmac !== MAC_A) begin n_err++; $display("FAIL rd_mac got %h want %h", rmac, MAC_A); end
        table_op(1'b1, 5'd3, 32'h0, 48'hFFFF_FFFF_FFFF, lat, rip, rmac);
        run_lookup(IP_A, lat, mac, hits, lks);
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL inval_lat got %0d want 33", lat); end
        n_cmp++; if (mac !== 48'h0) begin n_err++; $display("FAIL inval_mac got %h want 0", mac); end
        run_lookup(32'h0, lat, mac, hits, lks);
        n_cmp++; if (lat !== 33 || mac !== 48'h0) begin n_err++; $display("FAIL zero_ip got lat %0d mac %h want 33/0", lat, mac); end
        n_cmp++; if (hits !== 0) begin n_err++; $display("FAIL zero_ip_hits got %0d want 0", hits); end
    endtask

    task automatic test_op_during_search;
        int ack_n; int done_n; logic [31:0] rip; logic [47:0] rmac;
        @(posedge clk); #1;
        arp_lookup_req = 1'b1; arp_lookup_search_ip = 32'h0A00_0099;
        ack_n = -1; done_n = -1; rip = '0; rmac = '0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (n == 3) begin table_rd_req = 1'b1; table_rd_index = 5'd2; end
            if (arp_lookup_done) begin done_n = n; arp_lookup_req = 1'b0; end
            if (table_ack) begin ack_n = n; rip = table_rd_ip; rmac = table_rd_mac; table_rd_req = 1'b0; break; end
        end
        arp_lookup_req = 1'b0; table_rd_req = 1'b0;
        n_cmp++; if (done_n !== 33) begin n_err++; $display("FAIL held_op_done got %0d want 33", done_n); end
        n_cmp++; if (ack_n !== 35) begin n_err++; $display("FAIL held_op_ack got %0d want 35", ack_n); end
        n_cmp++; if (rip !== IP_DUP || rmac !== MAC_2) begin n_err++; $display("FAIL held_op_rd got %h/%h want %h/%h", rip, rmac, IP_DUP, MAC_2); end
    endtask

    task automatic test_abort;
        int dones; int lks; int lat; int hits; logic [47:0] mac;
        @(posedge clk); #1;
        arp_lookup_req = 1'b1; arp_lookup_search_ip = 32'h0A00_0099;
        dones = 0; lks = 0;
        for (int n = 0; n < 45; n++) begin
            @(negedge clk);
            if (n == 4) arp_lookup_req = 1'b0;
            if (arp_lookup_done) dones++;
            if (cntr_arp_lookups) lks++;
        end
        n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL abort_done got %0d want 0", dones); end
        n_cmp++; if (lks !== 1) begin n_err++; $display("FAIL abort_lookups got %0d want 1", lks); end
        run_lookup(IP_DUP, lat, mac, hits, lks);
        n_cmp++; if (lat !== 4 || mac !== MAC_2) begin n_err++; $display("FAIL post_abort got lat %0d mac %h want 4/%h", lat, mac, MAC_2); end
    endtask

    task automatic test_reset_mid;
        int dones; int lat; int hits; int lks; logic [31:0] rip; logic [47:0] rmac; logic [47:0] mac;
        @(posedge clk); #1;
        arp_lookup_req = 1'b1; arp_lookup_search_ip = IP_C;
        repeat (3) @(negedge clk);
        reset = 1'b1; arp_lookup_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (arp_lookup_done !== 1'b0 || table_ack !== 1'b0) begin n_err++; $display("FAIL rstmid_flags got %b/%b want 0/0", arp_lookup_done, table_ack); end
        n_cmp++; if (arp_lookup_result_mac !== 48'h0) begin n_err++; $display("FAIL rstmid_mac got %h want 0", arp_lookup_result_mac); end
        n_cmp++; if (table_rd_ip !== 32'h0 || table_rd_mac !== 48'h0) begin n_err++; $display("FAIL rstmid_rd got %h/%h want 0/0", table_rd_ip, table_rd_mac); end
        @(posedge clk); #1;
        reset = 1'b0;
        dones = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (arp_lookup_done) dones++;
        end
        n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL rstmid_done got %0d want 0", dones); end
        table_op(1'b0, 5'd5, 32'h0, 48'h0, lat, rip, rmac);
        n_cmp++; if (lat !== 1 || rip !== 32'h0 || rmac !== 48'h0) begin n_err++; $display("FAIL rstmid_cleared got lat %0d %h/%h want 1 0/0", lat, rip, rmac); end
        run_lookup(IP_C, lat, mac, hits, lks);
        n_cmp++; if (lat !== 33 || mac !== 48'h0) begin n_err++; $display("FAIL rstmid_miss got lat %0d mac %h want 33/0", lat, mac); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b1;
        arp_lookup_req = 1'b0; arp_lookup_search_ip = '0;
        table_wr_req = 1'b0; table_wr_index = '0; table_wr_ip = '0; table_wr_mac = '0;
        table_rd_req = 1'b0; table_rd_index = '0;
        test_reset();
        test_hit_idx3();
        test_empty_miss();
        test_duplicate();
        test_collision();
        test_readback_invalidate();
        test_op_during_search();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
